// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel write queue: coordinate width, default
// colour width, the buffered pixel record and the queue control states.
package pixel_pkg;

  localparam int COORD_W     = 11;
  localparam int PIX_COLOR_W = 1;

  // One buffered pixel as carried from the drawer to the frame buffer.
  typedef struct packed {
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [PIX_COLOR_W-1:0] color;
  } pixel_t;

  // Shape life cycle: waiting, collecting pixels, flushing, acknowledging.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    ACK    = 2'd3
  } pwq_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding accepted pixels until the frame buffer
// can take them. Pointers are log2(DEPTH) bits and wrap naturally; the
// occupancy register alone decides full/empty.
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   push, wdata    write request and payload (ignored when full)
//   pop, rdata     read request and head-of-queue payload (ignored when empty)
//   full, empty    occupancy flags
//   count          number of entries held
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int  DEPTH     = 8,
  parameter type payload_t = pixel_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  payload_t               wdata,
  input  logic                   pop,
  output payload_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  payload_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign rdata     = mem[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array; data path only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_queue.sv
// Consumer end of the shape-drawer pixel stream. Accepts one pixel per
// cycle, clips off-screen pixels, buffers the rest and issues single-cycle
// frame-buffer write strobes under backpressure. The drawer's end-of-shape
// pulse becomes shape_ack once every accepted pixel of the shape is written.
// Optional feature: define PIXEL_DEDUP_EN to suppress a pixel identical to
// the previous pushed pixel of the same shape (counted in drop_cnt).
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   pix_valid/pix_ready         drawer handshake; pix_x/pix_y/pix_color payload
//   shape_done / shape_ack      end-of-shape pulse in, completion pulse out
//   fb_busy                     frame buffer cannot take a write next cycle
//   fb_we/fb_x/fb_y/fb_color    registered frame-buffer write port
//   drop_cnt                    saturating count of clipped/suppressed pixels
module pixel_write_queue
  import pixel_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int COLOR_W = PIX_COLOR_W,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [10:0]        pix_x,
  input  logic [10:0]        pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  output logic               pix_ready,
  input  logic               shape_done,
  output logic               shape_ack,
  input  logic               fb_busy,
  output logic               fb_we,
  output logic [10:0]        fb_x,
  output logic [10:0]        fb_y,
  output logic [COLOR_W-1:0] fb_color,
  output logic [15:0]        drop_cnt
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pix_t;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] V_LIM    = COORD_W'(V_RES);
  localparam logic [15:0]        DROP_MAX = 16'hFFFF;

  pwq_state_e         state_r;
  pwq_state_e         state_next_s;
  pix_t               in_pix_s;
  pix_t               fifo_rdata_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               accept_s;
  logic               in_range_s;
  logic               dup_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  logic               fb_we_r;
  logic [COORD_W-1:0] fb_x_r;
  logic [COORD_W-1:0] fb_y_r;
  logic [COLOR_W-1:0] fb_color_r;
  logic               shape_ack_r;
  logic [15:0]        drop_cnt_r;

`ifdef PIXEL_DEDUP_EN
  logic last_valid_r;
  pix_t last_pix_r;
`endif

  assign in_pix_s.x     = pix_x;
  assign in_pix_s.y     = pix_y;
  assign in_pix_s.color = pix_color;

  // Ready depends only on registered state and occupancy, never on pix_valid.
  assign pix_ready = ((state_r == IDLE) || (state_r == ACTIVE)) && !fifo_full_s;

  // Input filter: clipping, optional duplicate suppression, push/drop/pop decode.
  always_comb begin
    accept_s   = pix_valid && pix_ready;
    in_range_s = (pix_x < H_LIM) && (pix_y < V_LIM);
`ifdef PIXEL_DEDUP_EN
    dup_s      = last_valid_r && (in_pix_s == last_pix_r);
`else
    dup_s      = 1'b0;
`endif
    push_s     = accept_s && in_range_s && !dup_s;
    drop_s     = accept_s && !push_s;
    pop_s      = !fifo_empty_s && !fb_busy;
  end

  // Next-state logic; a pixel taken alongside shape_done joins the closing shape.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (shape_done) begin
          state_next_s = DRAIN;
        end else if (accept_s) begin
          state_next_s = ACTIVE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACTIVE: begin
        if (shape_done) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      DRAIN: begin
        // Done only when nothing is buffered and the last strobe has retired.
        if ((fifo_count_s == {CNT_W{1'b0}}) && !fb_we_r) begin
          state_next_s = ACK;
        end else begin
          state_next_s = DRAIN;
        end
      end
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  pixel_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (pix_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (in_pix_s),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // State register and the registered acknowledge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      shape_ack_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      shape_ack_r <= (state_next_s == ACK);
    end
  end

  // Frame-buffer write port: strobe for one cycle per pop, hold data otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_we_r    <= 1'b0;
      fb_x_r     <= {COORD_W{1'b0}};
      fb_y_r     <= {COORD_W{1'b0}};
      fb_color_r <= {COLOR_W{1'b0}};
    end else begin
      fb_we_r <= pop_s;
      if (pop_s) begin
        fb_x_r     <= fifo_rdata_s.x;
        fb_y_r     <= fifo_rdata_s.y;
        fb_color_r <= fifo_rdata_s.color;
      end else begin
        fb_x_r     <= fb_x_r;
        fb_y_r     <= fb_y_r;
        fb_color_r <= fb_color_r;
      end
    end
  end

  // Saturating count of accepted pixels that were not pushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= 16'h0000;
    end else if (drop_s && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

`ifdef PIXEL_DEDUP_EN
  // Last pushed pixel of the current shape; forgotten when returning to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_valid_r <= 1'b0;
      last_pix_r   <= '{x: {COORD_W{1'b0}}, y: {COORD_W{1'b0}}, color: {COLOR_W{1'b0}}};
    end else if (push_s) begin
      last_valid_r <= 1'b1;
      last_pix_r   <= in_pix_s;
    end else if (state_next_s == IDLE) begin
      last_valid_r <= 1'b0;
      last_pix_r   <= last_pix_r;
    end else begin
      last_valid_r <= last_valid_r;
      last_pix_r   <= last_pix_r;
    end
  end
`endif

  assign fb_we     = fb_we_r;
  assign fb_x      = fb_x_r;
  assign fb_y      = fb_y_r;
  assign fb_color  = fb_color_r;
  assign shape_ack = shape_ack_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Scoreboard bench for pixel_write_queue: expected writes are queued when
// pixels are accepted and compared as fb_we strobes appear.
module tb_pixel_write_queue;

`ifdef PIXEL_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [0:0]  pix_color;
  logic        pix_ready;
  logic        shape_done;
  logic        shape_ack;
  logic        fb_busy;
  logic        fb_we;
  logic [10:0] fb_x;
  logic [10:0] fb_y;
  logic [0:0]  fb_color;
  logic [15:0] drop_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_cnt  = 0;
  int          exp_acks = 0;
  int          exp_drop = 0;
  logic [22:0] exp_q[$];
  logic [22:0] m_last;
  bit          m_last_valid = 1'b0;

  pixel_write_queue dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .pix_ready  (pix_ready),
    .shape_done (shape_done),
    .shape_ack  (shape_ack),
    .fb_busy    (fb_busy),
    .fb_we      (fb_we),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_color   (fb_color),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of one accepted pixel.
  task automatic model_accept(input int x, input int y, input int c);
    logic [22:0] e;
    e = {x[10:0], y[10:0], c[0]};
    if (x >= 640 || y >= 480) begin
      exp_drop++;
    end else if (DEDUP && m_last_valid && (e == m_last)) begin
      exp_drop++;
    end else begin
      exp_q.push_back(e);
      m_last       = e;
      m_last_valid = 1'b1;
    end
  endtask

  // Present one pixel (optionally with shape_done) and complete its handshake.
  task automatic send_pix(input int x, input int y, input int c, input bit done);
    int guard;
    guard     = 0;
    pix_x     = x[10:0];
    pix_y     = y[10:0];
    pix_color = c[0:0];
    pix_valid = 1'b1;
    while (!pix_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!pix_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      pix_valid = 1'b0;
    end else begin
      shape_done = done;
      @(posedge clk);
      model_accept(x, y, c);
      if (done) m_last_valid = 1'b0;
      @(negedge clk);
      pix_valid  = 1'b0;
      shape_done = 1'b0;
    end
  endtask

  task automatic pulse_done();
    shape_done = 1'b1;
    @(negedge clk);
    shape_done = 1'b0;
    m_last_valid = 1'b0;
  endtask

  task automatic wait_ack();
    int guard;
    guard = 0;
    exp_acks++;
    while (ack_cnt < exp_acks && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("ack_seen", ack_cnt, exp_acks);
    repeat (3) @(negedge clk);
    check("ack_once", ack_cnt, exp_acks);
    check("sb_empty", exp_q.size(), 32'd0);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          check("fb_unexp_we", 32'd1, 32'd0);
        end else begin
          check("fb_pix", {9'd0, fb_x, fb_y, fb_color}, {9'd0, exp_q.pop_front()});
        end
      end
      if (shape_ack) begin
        ack_cnt++;
        check("ack_after_writes", exp_q.size(), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    pix_valid  = 1'b0;
    pix_x      = 11'd0;
    pix_y      = 11'd0;
    pix_color  = 1'b0;
    shape_done = 1'b0;
    fb_busy    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", fb_we, 32'd0);
    check("rst_ack", shape_ack, 32'd0);
    check("rst_drop", drop_cnt, 32'd0);
    check("rst_fbxy", {fb_x, fb_y, fb_color}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", pix_ready, 32'd1);

    // 1: three pixels, latency and ordering.
    send_pix(10, 20, 1, 1'b0);
    check("lat_k1_no_we", fb_we, 32'd0);
    send_pix(11, 20, 1, 1'b0);
    check("lat_first_we", fb_we, 32'd1);
    check("lat_first_x", fb_x, 32'd10);
    send_pix(12, 20, 1, 1'b1);
    wait_ack();

    // 2: backpressure fills the FIFO, then drains in order.
    fb_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_pix(100 + i, 200 + i, i % 2, 1'b0);
    end
    check("full_ready", pix_ready, 32'd0);
    check("busy_no_we", fb_we, 32'd0);
    pulse_done();
    fb_busy = 1'b0;
    wait_ack();

    // 3: clipping boundaries.
    send_pix(640, 5, 1, 1'b0);
    send_pix(5, 480, 1, 1'b0);
    send_pix(639, 479, 0, 1'b1);
    wait_ack();
    check("clip_drop", drop_cnt, exp_drop);

    // 4: empty shape.
    shape_done = 1'b1;
    @(negedge clk);
    shape_done = 1'b0;
    check("empty_ack_early", shape_ack, 32'd0);
    @(negedge clk);
    check("empty_ack_2cyc", shape_ack, 32'd1);
    exp_acks++;
    repeat (3) @(negedge clk);
    check("empty_ack_cnt", ack_cnt, exp_acks);

    // 6: duplicate pixels.
    send_pix(5, 5, 1, 1'b0);
    send_pix(5, 5, 1, 1'b0);
    send_pix(6, 5, 1, 1'b1);
    wait_ack();
    check("dedup_drop", drop_cnt, exp_drop);

    // 5: reset while draining with four buffered pixels.
    fb_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_pix(300 + i, 50, 1, 1'b0);
    end
    pulse_done();
    repeat (2) @(negedge clk);
    fb_busy = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_we", fb_we, 32'd0);
    check("midrst_ack", shape_ack, 32'd0);
    exp_q.delete();
    exp_drop     = 0;
    m_last_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("midrst_ready", pix_ready, 32'd1);
    check("midrst_drop", drop_cnt, 32'd0);
    repeat (30) @(negedge clk);
    check("midrst_no_ack", ack_cnt, exp_acks);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
